// File: rtl/pci_arbiter_n_if.sv
// pci_arbiter_n_if -- request/grant bundle between bus requesters and the
// PCI-style arbiter.
//   req      requester -> arbiter  per-requester level-sensitive request
//   req_mask requester -> arbiter  1 = requester ignored when choosing a winner
//   gnt      arbiter -> requester  one-hot (or zero) registered grant
//   owner    arbiter -> requester  index of the granted requester, 0 when idle
//   aen      arbiter -> requester  bus-enable code, owner+1 while granted
//   preempt  arbiter -> requester  one-cycle pulse after a hold-limit revocation
interface pci_arbiter_n_if #(
    parameter int N_REQ = 4
);
    localparam int OW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] req_mask;
    logic [N_REQ-1:0] gnt;
    logic [OW-1:0]    owner;
    logic [OW:0]      aen;
    logic             preempt;

    // Requester side.
    modport master (
        output req, req_mask,
        input  gnt, owner, aen, preempt
    );

    // Arbiter side.
    modport slave (
        input  req, req_mask,
        output gnt, owner, aen, preempt
    );
endinterface

// File: rtl/pci_arbiter_n.sv
// pci_arbiter_n -- N-requester bus arbiter with IDLE / GRANT / TURN sequencing,
// fixed or round-robin priority and a hold limit that forces re-arbitration
// when other requesters are waiting.
//   clk    single system clock, rising edge
//   reset  synchronous, active-high
//   bus    pci_arbiter_n_if.slave: req, req_mask in; gnt, owner, aen, preempt out
// All outputs are registered.
module pci_arbiter_n #(
    parameter int N_REQ    = 4,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pci_arbiter_n_if.slave        bus
);
    localparam int OW = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW:0]      aen_q, aen_d;
    logic             pre_q, pre_d;
    logic [7:0]       hold_q, hold_d;
    logic [OW-1:0]    ptr_q, ptr_d;

    logic [N_REQ-1:0] elig;
    logic             owner_req;
    logic             others_pend;
    logic             win_found;
    logic [OW-1:0]    win_idx;
    logic [OW-1:0]    next_ptr;
    int               base;
    int               cand;

    // Masking only affects who may win; the current owner is judged on its
    // raw request so a masked owner keeps the bus.
    assign elig        = bus.req & ~bus.req_mask;
    assign owner_req   = |(bus.req & gnt_q);
    assign others_pend = |(elig & ~gnt_q);
    assign next_ptr    = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Winner search: walk N_REQ candidates starting at base, wrapping. Fixed
    // priority is the same walk anchored at index 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        base      = (RR_MODE != 0) ? int'(ptr_q) : 0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (base + k) % N_REQ;
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand[OW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        aen_d   = aen_q;
        pre_d   = 1'b0;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    gnt_d   = N_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    aen_d   = {1'b0, win_idx} + (OW+1)'(1);
                    hold_d  = 8'd1;
                end
            end
            S_GRANT: begin
                // Release when the owner lets go, or revoke once the hold limit
                // is reached and somebody else is waiting.
                if (!owner_req || (hold_q >= HOLD_MAX && others_pend)) begin
                    state_d = S_TURN;
                    gnt_d   = '0;
                    owner_d = '0;
                    aen_d   = '0;
                    hold_d  = '0;
                    ptr_d   = next_ptr;
                    pre_d   = owner_req;
                end else if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                owner_d = '0;
                aen_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            aen_q   <= '0;
            pre_q   <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            aen_q   <= aen_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.aen     = aen_q;
    assign bus.preempt = pre_q;

endmodule
